// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display scheduler
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    CONV = 2'd2,
    SHOW = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W     = 4;
  localparam logic [3:0]  DIGIT_BLANK = 4'hF;
  localparam int unsigned DISP_MAX    = 9999;

  // Replace leading zero digits with the blank code; the ones digit always shows.
  function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    if (bcd[15:12] == 4'd0) begin
      r[15:12] = DIGIT_BLANK;
      if (bcd[11:8] == 4'd0) begin
        r[11:8] = DIGIT_BLANK;
        if (bcd[7:4] == 4'd0) begin
          r[7:4] = DIGIT_BLANK;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_sched_bin2bcd.sv
// rtl/disp_sched_bin2bcd.sv - sequential double-dabble binary to 4-digit BCD
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_bin,
  output logic             o_done,
  output logic             o_busy,
  output logic [15:0]      o_bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] r_bin;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      w_adj;
  logic [15:0]      w_next;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  always_comb begin
    w_adj = r_acc;
    for (int n = 0; n < 4; n++) begin
      if (r_acc[n*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        w_adj[n*DIGIT_W +: DIGIT_W] = r_acc[n*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
    w_next = {w_adj[14:0], r_bin[VAL_W-1]};
  end

  // Load on start, then run exactly VAL_W steps; done pulses with the final result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bin  <= i_bin;
        r_acc  <= '0;
        r_cnt  <= CNT_W'(VAL_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_next;
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_busy = r_busy;
  assign o_bcd  = r_acc;

endmodule

// File: rtl/disp_sched.sv
// rtl/disp_sched.sv - round-robin display scheduler with BCD conversion; option DISP_LEADING_BLANK_EN
module disp_sched
  import disp_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int VAL_W       = 14,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*VAL_W-1:0] val_flat,
  output logic [NREQ-1:0]       grant,
  output logic [15:0]           digits,
  output logic                  digits_valid,
  output logic                  ovf,
  output logic                  busy
);

  localparam int RR_W   = $clog2(NREQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [RR_W-1:0]   r_rr;
  logic [HOLD_W-1:0] r_hold;
  logic [15:0]       r_digits;
  logic              r_valid;
  logic              r_ovf;

  logic              w_any;
  int                w_idx;
  logic [RR_W-1:0]   w_win;
  logic [VAL_W-1:0]  w_win_val;
  logic              w_over;
  logic [VAL_W-1:0]  w_clamp_val;
  logic              w_start;
  logic              w_done;
  logic              w_busy;
  logic [15:0]       w_bcd;
  logic [15:0]       w_disp;
  logic              w_owner_req;

  // Round-robin search upward from rr+1 with wrap; scanning far-to-near lets the nearest win.
  always_comb begin
    w_any = |req;
    w_win = r_rr;
    w_idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (req[RR_W'(w_idx)]) begin
        w_win = RR_W'(w_idx);
      end
    end
  end

  // Select the winner's value and clamp anything above the displayable maximum.
  always_comb begin
    w_win_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == RR_W'(i)) begin
        w_win_val = val_flat[i*VAL_W +: VAL_W];
      end
    end
    w_over      = (32'(w_win_val) > DISP_MAX);
    w_clamp_val = w_over ? VAL_W'(DISP_MAX) : w_win_val;
  end

  assign w_start     = (r_state == ARB) && w_any;
  assign w_owner_req = |(req & r_grant);

`ifdef DISP_LEADING_BLANK_EN
  assign w_disp = blank_leading(w_bcd);
`else
  assign w_disp = w_bcd;
`endif

  // The converter latches the clamped winner value on the ARB edge.
  bin2bcd_seq #(
    .VAL_W (VAL_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (w_clamp_val),
    .o_done  (w_done),
    .o_busy  (w_busy),
    .o_bcd   (w_bcd)
  );

  // Scheduler FSM: arbitrate, convert, then hold the owner on screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr     <= RR_W'(NREQ - 1);
      r_hold   <= '0;
      r_digits <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_grant  <= '0;
          r_digits <= '0;
          r_valid  <= 1'b0;
          if (w_any) begin
            r_state <= ARB;
          end
        end
        ARB: begin
          if (w_any) begin
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_rr    <= w_win;
            r_ovf   <= w_over;
            r_state <= CONV;
          end else begin
            r_grant  <= '0;
            r_digits <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_state  <= IDLE;
          end
        end
        CONV: begin
          // Previous digits stay visible until the whole conversion is done.
          if (w_done) begin
            r_digits <= w_disp;
            r_valid  <= 1'b1;
            r_hold   <= '0;
            r_state  <= SHOW;
          end
        end
        SHOW: begin
          if (!w_owner_req || (r_hold == HOLD_W'(HOLD_CYCLES - 1))) begin
            r_state <= ARB;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant        = r_grant;
  assign digits       = r_digits;
  assign digits_valid = r_valid;
  assign ovf          = r_ovf;
  assign busy         = w_busy;

endmodule

// File: tb/tb_disp_sched.sv
// tb/tb_disp_sched.sv - directed vector bench for disp_sched
module tb_disp_sched;

  localparam int NREQ  = 4;
  localparam int VAL_W = 14;
  localparam int HOLD  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*VAL_W-1:0] val_flat = '0;
  logic [NREQ-1:0]       grant;
  logic [15:0]           digits;
  logic                  digits_valid;
  logic                  ovf;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;
  int lat, bcnt, n, bad;

  typedef struct {
    logic [3:0] req;
    int         v0, v1, v2, v3;
    logic [3:0] exp_grant;
    int         exp_val;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] rr_seq[4];
  int         rr_val[4];

  always #5 clk = ~clk;

  disp_sched #(
    .NREQ        (NREQ),
    .VAL_W       (VAL_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .val_flat     (val_flat),
    .grant        (grant),
    .digits       (digits),
    .digits_valid (digits_valid),
    .ovf          (ovf),
    .busy         (busy)
  );

  function automatic logic [15:0] exp_dig(input int v);
    int d3, d2, d1, d0;
    logic [15:0] r;
    d3 = v / 1000;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    r = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
`ifdef DISP_LEADING_BLANK_EN
    if (d3 == 0) begin
      r[15:12] = 4'hF;
      if (d2 == 0) begin
        r[11:8] = 4'hF;
        if (d1 == 0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic set_vals(input int v0, input int v1, input int v2, input int v3);
    val_flat = {VAL_W'(v3), VAL_W'(v2), VAL_W'(v1), VAL_W'(v0)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_valid(output int l, output int b);
    l = -1;
    b = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (busy) b++;
      if (digits_valid) begin
        l = k - 1;
        break;
      end
    end
  endtask

  task automatic wait_grant(input logic [3:0] g, output int nn);
    nn = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (grant === g) begin
        nn = k;
        break;
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'b0001, 1234, 0, 0, 0, 4'b0001, 1234, 1'b0};
    tbl[1] = '{4'b0100, 0, 0, 12000, 0, 4'b0100, 9999, 1'b1};
    tbl[2] = '{4'b0100, 0, 0, 5, 0, 4'b0100, 5, 1'b0};
    tbl[3] = '{4'b1000, 0, 0, 0, 9999, 4'b1000, 9999, 1'b0};
    tbl[4] = '{4'b0010, 0, 10000, 0, 0, 4'b0010, 9999, 1'b1};
    tbl[5] = '{4'b0001, 0, 0, 0, 0, 4'b0001, 0, 1'b0};
    tbl[6] = '{4'b1010, 0, 42, 0, 8, 4'b0010, 42, 1'b0};
    tbl[7] = '{4'b1010, 0, 42, 0, 907, 4'b1000, 907, 1'b0};
    tbl[8] = '{4'b0101, 16383, 0, 3, 0, 4'b0001, 9999, 1'b1};
    tbl[9] = '{4'b0101, 1, 0, 3, 0, 4'b0100, 3, 1'b0};

    // Reset state
    #12;
    check("rst grant", 32'(grant), 0);
    check("rst digits", 32'(digits), 0);
    check("rst valid", 32'(digits_valid), 0);
    check("rst ovf", 32'(ovf), 0);
    check("rst busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single transactions, each returning to IDLE
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_vals(tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].v3);
      req = tbl[i].req;
      run_to_valid(lat, bcnt);
      check($sformatf("v%0d latency", i), 32'(lat), 16);
      check($sformatf("v%0d busy cycles", i), 32'(bcnt), 14);
      check($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].exp_grant));
      check($sformatf("v%0d digits", i), 32'(digits), 32'(exp_dig(tbl[i].exp_val)));
      check($sformatf("v%0d ovf", i), 32'(ovf), 32'(tbl[i].exp_ovf));
      @(negedge clk);
      req = '0;
      wait_grant(4'b0000, n);
      check($sformatf("v%0d release edges", i), 32'(n), 2);
      check($sformatf("v%0d idle digits", i), 32'(digits), 0);
      check($sformatf("v%0d idle valid", i), 32'(digits_valid), 0);
    end

    // Round-robin with hold expiry
    do_reset();
    rr_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rr_val = '{111, 222, 333, 111};
    @(negedge clk);
    set_vals(111, 222, 0, 333);
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_grant(rr_seq[k], n);
      check($sformatf("rr%0d grant edges", k), 32'(n), (k == 0) ? 2 : 9);
      for (int j = 0; j < 30; j++) begin
        if (!busy) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check($sformatf("rr%0d digits", k), 32'(digits), 32'(exp_dig(rr_val[k])));
      check($sformatf("rr%0d valid", k), 32'(digits_valid), 1);
    end

    // Early release in SHOW with nothing else pending
    do_reset();
    @(negedge clk);
    set_vals(77, 0, 0, 0);
    req = 4'b0001;
    run_to_valid(lat, bcnt);
    check("er digits", 32'(digits), 32'(exp_dig(77)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    check("er arb grant", 32'(grant), 32'h1);
    check("er arb valid", 32'(digits_valid), 1);
    @(posedge clk); #1;
    check("er idle grant", 32'(grant), 0);
    check("er idle valid", 32'(digits_valid), 0);
    check("er idle digits", 32'(digits), 0);

    // Asynchronous reset during a refresh conversion
    do_reset();
    @(negedge clk);
    set_vals(9, 55, 0, 0);
    req = 4'b0010;
    run_to_valid(lat, bcnt);
    check("ar first grant", 32'(grant), 32'h2);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (busy) begin
        n = k;
        break;
      end
    end
    check("ar refresh started", 32'(n > 0), 1);
    repeat (6) @(posedge clk);
    #2;
    check("ar pre valid", 32'(digits_valid), 1);
    check("ar pre busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("ar grant", 32'(grant), 0);
    check("ar digits", 32'(digits), 0);
    check("ar valid", 32'(digits_valid), 0);
    check("ar busy", 32'(busy), 0);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    run_to_valid(lat, bcnt);
    check("ar restart latency", 32'(lat), 16);
    check("ar restart grant", 32'(grant), 32'h1);
    check("ar restart digits", 32'(digits), 32'(exp_dig(9)));

    // No pre-emption while an owner is on screen
    do_reset();
    @(negedge clk);
    set_vals(1, 600, 0, 0);
    req = 4'b0010;
    run_to_valid(lat, bcnt);
    @(negedge clk);
    req = 4'b0011;
    n = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (grant !== 4'b0010) begin
        n = k;
        break;
      end
    end
    check("np switch edge", 32'(n), 9);
    check("np new grant", 32'(grant), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
